ramdp_arb: RTL

- Arbiter and sequencer that shares one dual-port RAM (two read/write ports, 1-cycle registered read, read-first per port) among N requesters.
- Each cycle it grants up to two requests, one per RAM port, using round-robin priority.
- It blocks same-cycle address collisions that involve a write.
- It returns read data to the owning requester one cycle after the grant.
- It sits between the client logic and the external dual-port RAM instance; it contains no storage array itself.

---
 rtl/ramdp_arb_pkg.sv | 14 +
 rtl/ramdp_arb_rr.sv | 30 +++
 rtl/ramdp_arb.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ramdp_arb_pkg.sv
// Shared state encoding and packed-bus slicing helper for the dual-port RAM arbiter.
package ramdp_arb_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Bit position of requester idx's field in a packed bus of w-bit fields.
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage

// File: rtl/ramdp_arb_rr.sv
// Rotating-priority finder: first set bit of mask scanning upward from start, modulo N.
module ramdp_arb_rr #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] idx
);

   int unsigned pos;

   // Scan N positions starting at start and keep the first hit.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int k = 0; k < N; k++) begin
         pos = (int'(start) + k) % N;
         if (!found && mask[pos]) begin
            found = 1'b1;
            idx   = IW'(pos);
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/ramdp_arb.sv
// Round-robin arbiter sharing one external dual-port RAM among N requesters.
// Define RAMDP_ARB_INIT_EN to zero the whole RAM through both ports after reset.
module ramdp_arb
   import ramdp_arb_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 6,
   parameter int N  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_valid,
   input  logic [N-1:0]    req_we,
   input  logic [N*AW-1:0] req_addr,
   input  logic [N*DW-1:0] req_din,
   output logic [N-1:0]    req_ready,
   output logic [N-1:0]    rsp_valid,
   output logic [N*DW-1:0] rsp_dout,
   output logic            init_done,
   output logic            en_a,
   output logic            we_a,
   output logic [AW-1:0]   addr_a,
   output logic [DW-1:0]   din_a,
   input  logic [DW-1:0]   dout_a,
   output logic            en_b,
   output logic            we_b,
   output logic [AW-1:0]   addr_b,
   output logic [DW-1:0]   din_b,
   input  logic [DW-1:0]   dout_b
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
`ifdef RAMDP_ARB_INIT_EN
   localparam state_e RST_STATE = ST_INIT;
`else
   localparam state_e RST_STATE = ST_RUN;
`endif

   state_e          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [N-1:0]    gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
   logic [N*DW-1:0] rsp_dout_q, rsp_dout_d;
`ifdef RAMDP_ARB_INIT_EN
   logic [AW-2:0]   cnt_q, cnt_d;
`endif

   logic [AW-1:0]   addr_arr [N];
   logic [DW-1:0]   din_arr  [N];
   logic            found_a, found_b;
   logic [IW-1:0]   idx_a, idx_b, start_b;
   logic [N-1:0]    mask_b;
   logic            run_s, collide, grant_a, grant_b;

   ramdp_arb_rr #(.N(N), .IW(IW)) u_rr_a (
      .mask (req_valid),
      .start(rr_ptr_q),
      .found(found_a),
      .idx  (idx_a)
   );

   ramdp_arb_rr #(.N(N), .IW(IW)) u_rr_b (
      .mask (mask_b),
      .start(start_b),
      .found(found_b),
      .idx  (idx_b)
   );

   // Unpack requester fields; port B searches just past port A's winner.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         addr_arr[i] = req_addr[slice_lo(i, AW) +: AW];
         din_arr[i]  = req_din[slice_lo(i, DW) +: DW];
      end
      mask_b = req_valid & ~(N'(1) << idx_a);
      if (idx_a == LAST_IDX) begin
         start_b = '0;
      end else begin
         start_b = idx_a + IW'(1);
      end
   end

   // Grants, RAM port drive, pointer advance and INIT/RUN sequencing.
   always_comb begin
      run_s   = (state_q == ST_RUN) && !rst;
      collide = found_b && (addr_arr[idx_b] == addr_arr[idx_a]) && (req_we[idx_a] || req_we[idx_b]);
      grant_a = run_s && found_a;
      grant_b = run_s && found_b && !collide;
      gnt_a_d = '0;
      gnt_b_d = '0;
      if (grant_a) begin
         gnt_a_d[idx_a] = 1'b1;
      end else begin
         gnt_a_d = '0;
      end
      if (grant_b) begin
         gnt_b_d[idx_b] = 1'b1;
      end else begin
         gnt_b_d = '0;
      end
      req_ready = gnt_a_d | gnt_b_d;

      if (grant_b) begin
         rr_ptr_d = (idx_b == LAST_IDX) ? '0 : idx_b + IW'(1);
      end else if (grant_a) begin
         rr_ptr_d = (idx_a == LAST_IDX) ? '0 : idx_a + IW'(1);
      end else begin
         rr_ptr_d = rr_ptr_q;
      end

      en_a   = grant_a;
      we_a   = grant_a && req_we[idx_a];
      addr_a = addr_arr[idx_a];
      din_a  = din_arr[idx_a];
      en_b   = grant_b;
      we_b   = grant_b && req_we[idx_b];
      addr_b = addr_arr[idx_b];
      din_b  = din_arr[idx_b];

      state_d = state_q;
`ifdef RAMDP_ARB_INIT_EN
      cnt_d = cnt_q;
`endif
      case (state_q)
         ST_INIT: begin
`ifdef RAMDP_ARB_INIT_EN
            // Even addresses on port A, odd on port B, zero data.
            en_a   = !rst;
            we_a   = !rst;
            addr_a = {cnt_q, 1'b0};
            din_a  = '0;
            en_b   = !rst;
            we_b   = !rst;
            addr_b = {cnt_q, 1'b1};
            din_b  = '0;
            cnt_d  = cnt_q + (AW-1)'(1);
            if (cnt_q == '1) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_INIT;
            end
`else
            state_d = ST_RUN;
`endif
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   // Route each granted port's read data to its owner; other slices hold.
   always_comb begin
      rsp_valid = (gnt_a_q | gnt_b_q) & {N{!rst}};
      rsp_dout  = rsp_dout_q;
      for (int i = 0; i < N; i++) begin
         if (rsp_valid[i] && gnt_a_q[i]) begin
            rsp_dout[slice_lo(i, DW) +: DW] = dout_a;
         end else if (rsp_valid[i] && gnt_b_q[i]) begin
            rsp_dout[slice_lo(i, DW) +: DW] = dout_b;
         end else begin
            rsp_dout[slice_lo(i, DW) +: DW] = rsp_dout_q[slice_lo(i, DW) +: DW];
         end
      end
      rsp_dout_d = rsp_dout;
   end

`ifdef RAMDP_ARB_INIT_EN
   assign init_done = (state_q == ST_RUN);
`else
   assign init_done = 1'b1;
`endif

   // State, round-robin pointer and response pipeline registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RST_STATE;
         rr_ptr_q   <= '0;
         gnt_a_q    <= '0;
         gnt_b_q    <= '0;
         rsp_dout_q <= '0;
`ifdef RAMDP_ARB_INIT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_a_q    <= gnt_a_d;
         gnt_b_q    <= gnt_b_d;
         rsp_dout_q <= rsp_dout_d;
`ifdef RAMDP_ARB_INIT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

endmodule
